// File: rtl/cmp_window_tracker.sv
// Windowed tally of comparator results with an on-line flag checker; one report per WINDOW samples.
// Optional CMP_WINDOW_STREAK_EN adds rpt_eq_streak (longest run of equal samples in the window).
module cmp_window_tracker #(
    parameter int WIDTH  = 4,
    parameter int WINDOW = 16,
    localparam int CW    = $clog2(WINDOW + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_g,
    input  logic             in_l,
    input  logic             in_e,
    output logic             rpt_valid,
    input  logic             rpt_ready,
    output logic [CW-1:0]    rpt_gt_cnt,
    output logic [CW-1:0]    rpt_lt_cnt,
    output logic [CW-1:0]    rpt_eq_cnt,
    output logic [CW-1:0]    rpt_err_cnt
`ifdef CMP_WINDOW_STREAK_EN
    ,
    output logic [CW-1:0]    rpt_eq_streak
`endif
);

    // state  | meaning
    // IDLE   | no samples accepted in the current window
    // ACCUM  | 1..WINDOW-1 samples accepted
    // REPORT | report held on rpt_* until rpt_ready
    typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

    localparam logic [CW-1:0] WIN_C = CW'(WINDOW);

    state_t        state;
    logic [CW-1:0] idx, gt_cnt, lt_cnt, eq_cnt, err_cnt;
    logic [CW-1:0] idx_nxt, gt_nxt, lt_nxt, eq_nxt, err_nxt;
    logic          cmp_gt, cmp_lt, cmp_eq, flag_err, accept, last;

    assign in_ready = (state != REPORT);
    assign accept   = in_valid & in_ready;

    // Recompute the comparison locally so the upstream flags can be audited.
    assign cmp_gt   = (in_a > in_b);
    assign cmp_lt   = (in_a < in_b);
    assign cmp_eq   = (in_a == in_b);
    assign flag_err = ({in_g, in_l, in_e} != {cmp_gt, cmp_lt, cmp_eq});

    assign idx_nxt = idx + CW'(1);
    assign gt_nxt  = gt_cnt + CW'(cmp_gt);
    assign lt_nxt  = lt_cnt + CW'(cmp_lt);
    assign eq_nxt  = eq_cnt + CW'(cmp_eq);
    assign err_nxt = err_cnt + CW'(flag_err);
    assign last    = (idx_nxt == WIN_C);

`ifdef CMP_WINDOW_STREAK_EN
    logic [CW-1:0] run, best, run_nxt, best_nxt;
    assign run_nxt  = cmp_eq ? run + CW'(1) : '0;
    assign best_nxt = (run_nxt > best) ? run_nxt : best;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            gt_cnt      <= '0;
            lt_cnt      <= '0;
            eq_cnt      <= '0;
            err_cnt     <= '0;
            rpt_valid   <= 1'b0;
            rpt_gt_cnt  <= '0;
            rpt_lt_cnt  <= '0;
            rpt_eq_cnt  <= '0;
            rpt_err_cnt <= '0;
`ifdef CMP_WINDOW_STREAK_EN
            run           <= '0;
            best          <= '0;
            rpt_eq_streak <= '0;
`endif
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        idx     <= idx_nxt;
                        gt_cnt  <= gt_nxt;
                        lt_cnt  <= lt_nxt;
                        eq_cnt  <= eq_nxt;
                        err_cnt <= err_nxt;
`ifdef CMP_WINDOW_STREAK_EN
                        run  <= run_nxt;
                        best <= best_nxt;
`endif
                        if (last) begin
                            state       <= REPORT;
                            rpt_valid   <= 1'b1;
                            rpt_gt_cnt  <= gt_nxt;
                            rpt_lt_cnt  <= lt_nxt;
                            rpt_eq_cnt  <= eq_nxt;
                            rpt_err_cnt <= err_nxt;
`ifdef CMP_WINDOW_STREAK_EN
                            rpt_eq_streak <= best_nxt;
`endif
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                REPORT: begin
                    // rpt_* values stay put after the handshake; only rpt_valid drops.
                    if (rpt_ready) begin
                        state     <= IDLE;
                        rpt_valid <= 1'b0;
                        idx       <= '0;
                        gt_cnt    <= '0;
                        lt_cnt    <= '0;
                        eq_cnt    <= '0;
                        err_cnt   <= '0;
`ifdef CMP_WINDOW_STREAK_EN
                        run  <= '0;
                        best <= '0;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
